window_stream_packer: RTL and testbench
=======================================

# window_stream_packer

Back end of the 7x7 convolution datapath. It consumes the per-pixel result stream produced downstream of the KxK window generator and discards results whose window is incomplete: fill rows, or windows that wrap across a row boundary. It emits the valid (IMG_Width-K+1) x (IMG_Height-K+1) output image in raster order with frame/line markers. It sits between the kernel arithmetic and the output image sink or writer.

## Interface
- IMG_Width, 8, input image width in pixels; must be ≥ K
- IMG_Height, 8, input image height in pixels; must be ≥ K
- Datawidth, 8, result sample width
- K, 7, kernel size (window is K x K)

Ports:
- CLK  in  1  clock; all logic on rising edge
- CLR  in  1  reset, synchronous, active-high
- SOF_IN  in  1  marks the beat carrying input pixel (0,0); sampled only with Valid_IN
- Valid_IN  in  1  one beat per input raster pixel
- In  in  Datawidth  kernel result for the window whose bottom-right pixel is the current raster pixel
- Out  out  Datawidth  packed output sample
- Valid_OUT  out  1  Out is a valid output pixel
- SOF_OUT  out  1  with Valid_OUT: first output pixel of frame
- EOL_OUT  out  1  with Valid_OUT: last output pixel of a line
- EOF_OUT  out  1  with Valid_OUT: last output pixel of frame
- Abort  out  1  one-cycle pulse: frame restarted before completion

## Operation
- Counters: col in 0..IMG_Width-1, row in 0..IMG_Height-1, both advance only on Valid_IN; col wraps to 0 and increments row.
- States:
  - IDLE: Valid_IN without SOF_IN is ignored.
  - IDLE → FILL on Valid_IN&SOF_IN; that beat is (0,0), so set col=1, row=0.
  - FILL → ACTIVE when a beat with row==K-1 is accepted.
  - ACTIVE → IDLE after accepting beat (IMG_Width-1, IMG_Height-1).
- Keep rule: a beat at (col,row) is forwarded iff col ≥ K-1 and row ≥ K-1. All other beats are dropped silently.
- Markers, evaluated on kept beats:
  - SOF_OUT when col==K-1 && row==K-1.
  - EOL_OUT when col==IMG_Width-1.
  - EOF_OUT when col==IMG_Width-1 && row==IMG_Height-1.
- SOF_IN&Valid_IN in FILL or ACTIVE: pulse Abort, treat the beat as new (0,0) and stay in or return to FILL. No EOF_OUT is emitted for the aborted frame.
- SOF_IN on the final beat of a frame: not an abort. The final beat completes normally with EOF, and the next frame starts on the following SOF_IN.
- Valid_IN low: counters, state and outputs hold, except Valid_OUT, the markers and Abort, which drop to 0.
- Degenerate case K=1: every beat is kept; FILL is skipped, so IDLE goes directly to ACTIVE.

## Timing
- Latency is 1 cycle: a kept beat at edge n appears on Out/Valid_OUT after edge n and is valid during cycle n+1. All outputs are registered.
- Reset values: Out=0, Valid_OUT=0, SOF_OUT=0, EOL_OUT=0, EOF_OUT=0, Abort=0, state=IDLE, col=0, row=0.
- CLR takes priority over all inputs. CLR mid-frame returns to IDLE with no Abort pulse.
- There is no backpressure: the sink must accept every Valid_OUT beat.
- Back-to-back frames are supported: SOF_IN may arrive on the cycle right after the final beat, with zero idle cycles.
- Out holds its last value while Valid_OUT=0; the sink must not interpret it.

## Structure
- Shared package/include holds:
  - state encodings IDLE=2'd0, FILL=2'd1, ACTIVE=2'd2;
  - the width helper for $clog2 counter sizing: col is $clog2(IMG_Width) bits, row is $clog2(IMG_Height) bits.
- One sub-module, raster_pos_counter, is natural: parameterised width/height, with advance, restart-to-(1,0) and clear inputs, and col, row and last-pixel outputs.
- The FSM, keep logic and output registers live in the top module.

## Test plan
All scenarios use the default parameters (8x8, K=7), which gives a 2x2 output.
- CLR held 3 cycles, then released: all outputs 0, and Valid_IN without SOF_IN produces no Valid_OUT.
- Full frame, In = raster index 0..63, continuous Valid_IN:
  - exactly 4 Valid_OUT beats, Out = 54, 55, 62, 63;
  - SOF_OUT on 54, EOL_OUT on 55 and 63, EOF_OUT on 63 only;
  - each output appears 1 cycle after its input.
- Same frame with Valid_IN deasserted every other cycle: same 4 outputs and markers, each 1 cycle after its accepted beat, with no duplicates.
- SOF_IN re-asserted at raster index 58:
  - Abort pulses once, and no EOF_OUT is emitted for the first frame;
  - a following full frame yields 54, 55, 62, 63 correctly.
- Two frames back-to-back with zero gap: 8 outputs, and EOF_OUT at cycle t is followed by SOF_OUT 55 cycles later (the position of index 54 in frame 2).
- CLR asserted at raster index 60: no further Valid_OUT, and the next SOF frame behaves as the full-frame case.

Source files
------------

// File: rtl/window_stream_packer_pkg.sv
// Shared types and sizing helpers for the window stream packer.
package window_stream_packer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_stream_packer_if.sv
// Result stream in, packed image stream out, grouped as one bundle.
interface window_stream_packer_if #(
    parameter int Datawidth = 8
);
    logic                 SOF_IN;
    logic                 Valid_IN;
    logic [Datawidth-1:0] In;
    logic [Datawidth-1:0] Out;
    logic                 Valid_OUT;
    logic                 SOF_OUT;
    logic                 EOL_OUT;
    logic                 EOF_OUT;
    logic                 Abort;

    modport master (
        output SOF_IN, Valid_IN, In,
        input  Out, Valid_OUT, SOF_OUT, EOL_OUT, EOF_OUT, Abort
    );

    modport slave (
        input  SOF_IN, Valid_IN, In,
        output Out, Valid_OUT, SOF_OUT, EOL_OUT, EOF_OUT, Abort
    );
endinterface

// File: rtl/window_stream_packer_raster_pos_counter.sv
// Raster (col,row) position tracker; restart loads the position that follows (0,0).
module raster_pos_counter
    import window_stream_packer_pkg::*;
#(
    parameter int IMG_Width  = 8,
    parameter int IMG_Height = 8,
    parameter int COL_W      = cnt_width(IMG_Width),
    parameter int ROW_W      = cnt_width(IMG_Height)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             advance,
    input  logic             restart,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_pixel
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_Width - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_Height - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (restart) begin
            // The (0,0) beat is consumed this cycle, so step one past it.
            if (COL_MAX == '0) begin
                col_d = '0;
                row_d = (ROW_MAX == '0) ? '0 : ROW_W'(1);
            end else begin
                col_d = COL_W'(1);
                row_d = '0;
            end
        end else if (advance) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign last_pixel = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/window_stream_packer.sv
// Drops results of incomplete KxK windows and emits the valid output image with frame/line markers.
module window_stream_packer
    import window_stream_packer_pkg::*;
#(
    parameter int IMG_Width  = 8,
    parameter int IMG_Height = 8,
    parameter int Datawidth  = 8,
    parameter int K          = 7
) (
    input  logic                  CLK,
    input  logic                  CLR,
    window_stream_packer_if.slave bus
);

    localparam int COL_W = cnt_width(IMG_Width);
    localparam int ROW_W = cnt_width(IMG_Height);

    localparam logic [COL_W-1:0] COL_KEEP = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_KEEP = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_Width - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_Height - 1);

    state_t state_q, state_d;

    logic [COL_W-1:0] cnt_col, cur_col;
    logic [ROW_W-1:0] cnt_row, cur_row;
    logic             cnt_last, cur_last;
    logic             abort_now, start, accept, keep;

    logic [Datawidth-1:0] out_q, out_d;
    logic valid_q, valid_d;
    logic sof_q, sof_d;
    logic eol_q, eol_d;
    logic eof_q, eof_d;
    logic abort_q, abort_d;

    // SOF on the final beat of a frame just completes it; anywhere else mid-frame it restarts.
    always_comb begin
        abort_now = bus.Valid_IN && bus.SOF_IN && (state_q != IDLE) && !cnt_last;
        start     = bus.Valid_IN && bus.SOF_IN && ((state_q == IDLE) || abort_now);
        accept    = start || (bus.Valid_IN && (state_q != IDLE));
        cur_col   = start ? '0 : cnt_col;
        cur_row   = start ? '0 : cnt_row;
        cur_last  = (cur_col == COL_MAX) && (cur_row == ROW_MAX);
    end

    raster_pos_counter #(
        .IMG_Width (IMG_Width),
        .IMG_Height(IMG_Height),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) u_pos (
        .clk       (CLK),
        .clear     (CLR),
        .advance   (accept && !start),
        .restart   (start),
        .col       (cnt_col),
        .row       (cnt_row),
        .last_pixel(cnt_last)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (cur_last) begin
                state_d = IDLE;
            end else if (cur_row >= ROW_KEEP) begin
                state_d = ACTIVE;
            end else begin
                state_d = FILL;
            end
        end
    end

    always_comb begin
        keep    = accept && (cur_col >= COL_KEEP) && (cur_row >= ROW_KEEP);
        out_d   = keep ? bus.In : out_q;
        valid_d = keep;
        sof_d   = keep && (cur_col == COL_KEEP) && (cur_row == ROW_KEEP);
        eol_d   = keep && (cur_col == COL_MAX);
        eof_d   = keep && cur_last;
        abort_d = abort_now;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            abort_q <= abort_d;
        end
    end

    assign bus.Out       = out_q;
    assign bus.Valid_OUT = valid_q;
    assign bus.SOF_OUT   = sof_q;
    assign bus.EOL_OUT   = eol_q;
    assign bus.EOF_OUT   = eof_q;
    assign bus.Abort     = abort_q;

endmodule

// File: tb/tb_window_stream_packer.sv
// Scoreboard bench: the driver states each beat's intended raster index, expected pixels are queued, a monitor checks them.
module tb_window_stream_packer;
    import window_stream_packer_pkg::*;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int KK = 7;
    localparam int N  = W * H;

    typedef struct {
        int data;
        int sof;
        int eol;
        int eof;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    exp_t exp_q[$];
    int   abort_q[$];

    window_stream_packer_if #(.Datawidth(8)) bus ();

    window_stream_packer #(
        .IMG_Width (W),
        .IMG_Height(H),
        .Datawidth (8),
        .K         (KK)
    ) dut (
        .CLK(clk),
        .CLR(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // A pixel is part of the output image only if its whole window lies inside the frame.
    task automatic apply_stimulus(input bit sof, input int pos, input bit exp_abort, input int data);
        exp_t e;
        int col, row;
        @(posedge clk);
        #1;
        bus.Valid_IN = 1'b1;
        bus.SOF_IN   = sof;
        bus.In       = data[7:0];
        if (pos >= 0) begin
            col = pos % W;
            row = pos / W;
            if (col >= KK - 1 && row >= KK - 1) begin
                e.data = data & 255;
                e.sof  = int'(col == KK - 1 && row == KK - 1);
                e.eol  = int'(col == W - 1);
                e.eof  = int'(col == W - 1 && row == H - 1);
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
        end
        if (exp_abort) abort_q.push_back(cyc + 1);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        bus.Valid_IN = 1'b0;
        bus.SOF_IN   = 1'($urandom % 2);
        bus.In       = 8'($urandom);
    endtask

    task automatic maybe_gap(input int gap_mode);
        if (gap_mode == 1 || (gap_mode == 2 && ($urandom % 3) == 0)) idle_cycle();
    endtask

    task automatic send_frame(input int gap_mode, input bit rnd_data, input bit last_sof);
        for (int p = 0; p < N; p++) begin
            apply_stimulus((p == 0) || (p == N - 1 && last_sof), p, 1'b0,
                           rnd_data ? int'($urandom % 256) : p);
            maybe_gap(gap_mode);
        end
    endtask

    task automatic send_aborted(input int abort_at, input int gap_mode);
        for (int p = 0; p < abort_at; p++) begin
            apply_stimulus(p == 0, p, 1'b0, int'($urandom % 256));
            maybe_gap(gap_mode);
        end
        apply_stimulus(1'b1, 0, 1'b1, int'($urandom % 256));
        for (int p = 1; p < N; p++) begin
            apply_stimulus(1'b0, p, 1'b0, int'($urandom % 256));
            maybe_gap(gap_mode);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (bus.Valid_OUT) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output("out_data", int'(bus.Out), e.data);
                check_output("sof_out", int'(bus.SOF_OUT), e.sof);
                check_output("eol_out", int'(bus.EOL_OUT), e.eol);
                check_output("eof_out", int'(bus.EOF_OUT), e.eof);
                check_output("output_cycle", cyc, e.cyc);
            end
        end else if (!clr) begin
            check_output("idle_markers", int'({bus.SOF_OUT, bus.EOL_OUT, bus.EOF_OUT}), 0);
        end
        if (bus.Abort) begin
            if (abort_q.size() == 0) begin
                check_output("unexpected_abort", 1, 0);
            end else begin
                a = abort_q.pop_front();
                check_output("abort_cycle", cyc, a);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        bus.Valid_IN = 1'b0;
        bus.SOF_IN   = 1'b0;
        bus.In       = 8'h00;

        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_out", int'(bus.Out), 0);
        check_output("reset_valid", int'(bus.Valid_OUT), 0);
        check_output("reset_sof", int'(bus.SOF_OUT), 0);
        check_output("reset_eol", int'(bus.EOL_OUT), 0);
        check_output("reset_eof", int'(bus.EOF_OUT), 0);
        check_output("reset_abort", int'(bus.Abort), 0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        for (int i = 0; i < 70; i++) apply_stimulus(1'b0, -1, 1'b0, 63);

        send_frame(0, 1'b0, 1'b0);
        repeat (3) idle_cycle();
        send_frame(1, 1'b1, 1'b0);
        idle_cycle();
        send_aborted(58, 0);
        send_frame(0, 1'b1, 1'b0);
        send_frame(0, 1'b1, 1'b1);
        send_frame(0, 1'b1, 1'b0);

        for (int p = 0; p < 60; p++) apply_stimulus(p == 0, p, 1'b0, int'($urandom % 256));
        @(posedge clk);
        #1;
        clr          = 1'b1;
        bus.Valid_IN = 1'b1;
        bus.SOF_IN   = 1'b0;
        bus.In       = 8'd60;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int p = 61; p < N; p++) apply_stimulus(1'b0, -1, 1'b0, p);
        send_frame(0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            r = int'($urandom % 4);
            case (r)
                0: send_frame(2, 1'b1, 1'b0);
                1: send_aborted(1 + int'($urandom % (N - 2)), 2);
                2: for (int j = 0; j < 5; j++) apply_stimulus(1'b0, -1, 1'b0, int'($urandom % 256));
                default: begin
                    send_frame(0, 1'b1, 1'b1);
                    send_frame(0, 1'b1, 1'b0);
                end
            endcase
        end

        repeat (4) idle_cycle();
        check_output("pending_outputs", exp_q.size(), 0);
        check_output("pending_aborts", abort_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
